// File: rtl/goose_pkg.sv
// Shared types, default 640x480@60 timing and helpers for the goose animation sequencer.
package goose_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SPIN     = 2'd1,
    STOPPING = 2'd2
  } anim_state_t;

  localparam int unsigned POS_W        = 10;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned NUM_FRAMES_DEF  = 8;
  localparam int unsigned HOLD_FRAMES_DEF = 8;

  // Video frames each sprite frame is held: max(1, hold_frames >> speed).
  function automatic int unsigned hold_len(input int unsigned hold_frames,
                                           input logic [1:0]  speed);
    int unsigned h;
    h = hold_frames >> speed;
    return (h == 32'd0) ? 32'd1 : h;
  endfunction

endpackage

// File: rtl/goose_anim_sequencer_if.sv
// Control requests in, raster position and animation selection out.
interface goose_anim_sequencer_if
  import goose_pkg::*;
#(
  parameter int unsigned IDX_W = 3
);

  logic              tick_en;
  logic              start;
  logic              stop;
  logic [1:0]        speed;

  logic [POS_W-1:0]  hpos;
  logic [POS_W-1:0]  vpos;
  logic              hsync;
  logic              vsync;
  logic              display_on;
  logic              frame_start;
  logic [IDX_W-1:0]  anim_idx;
  anim_state_t       anim_state;
  logic              busy;

  modport master (
    output tick_en, start, stop, speed,
    input  hpos, vpos, hsync, vsync, display_on, frame_start,
    input  anim_idx, anim_state, busy
  );

  modport slave (
    input  tick_en, start, stop, speed,
    output hpos, vpos, hsync, vsync, display_on, frame_start,
    output anim_idx, anim_state, busy
  );

endinterface

// File: rtl/goose_anim_sequencer_vga_timing.sv
// Raster counters with sync/display decode and a registered frame_start pulse.
module vga_timing
  import goose_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_en_i,
  output logic [POS_W-1:0] hpos_o,
  output logic [POS_W-1:0] vpos_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             display_on_o,
  output logic             frame_start_o
);

  localparam int unsigned H_LEN  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_LEN  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;

  logic [POS_W-1:0] hpos_q, hpos_d;
  logic [POS_W-1:0] vpos_q, vpos_d;
  logic             frame_start_q, frame_start_d;
  logic             h_last, v_last;

  always_comb begin
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    frame_start_d = 1'b0;
    h_last        = (hpos_q == POS_W'(H_LEN - 1));
    v_last        = (vpos_q == POS_W'(V_LEN - 1));
    if (tick_en_i) begin
      if (h_last) begin
        hpos_d = '0;
        if (v_last) begin
          vpos_d        = '0;
          frame_start_d = 1'b1;
        end else begin
          vpos_d = vpos_q + POS_W'(1);
        end
      end else begin
        hpos_d = hpos_q + POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hpos_q        <= '0;
      vpos_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Sync and blanking are a pure decode of the registered position.
  assign hsync_o       = !((hpos_q >= POS_W'(HS_BEG)) && (hpos_q < POS_W'(HS_END)));
  assign vsync_o       = !((vpos_q >= POS_W'(VS_BEG)) && (vpos_q < POS_W'(VS_END)));
  assign display_on_o  = (hpos_q < POS_W'(H_ACTIVE)) && (vpos_q < POS_W'(V_ACTIVE));
  assign hpos_o        = hpos_q;
  assign vpos_o        = vpos_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/goose_anim_sequencer.sv
// Raster timing plus a frame-synchronous spin FSM selecting the goose sprite frame.
module goose_anim_sequencer
  import goose_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned H_FP        = H_FP_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BP        = H_BP_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned V_FP        = V_FP_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BP        = V_BP_DEF,
  parameter int unsigned NUM_FRAMES  = NUM_FRAMES_DEF,
  parameter int unsigned HOLD_FRAMES = HOLD_FRAMES_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  goose_anim_sequencer_if.slave gfx_io
);

  localparam int unsigned IDX_W = $clog2(NUM_FRAMES);
  localparam int unsigned CNT_W = $clog2(HOLD_FRAMES + 1);

  logic [POS_W-1:0] hpos, vpos;
  logic             hsync, vsync, display_on, frame_start;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .tick_en_i     (gfx_io.tick_en),
    .hpos_o        (hpos),
    .vpos_o        (vpos),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .display_on_o  (display_on),
    .frame_start_o (frame_start)
  );

  anim_state_t      state_q, state_d, target;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hold_m1;
  logic [1:0]       spd_q, spd_d;
  logic             start_pend_q, start_pend_d;
  logic             stop_pend_q, stop_pend_d;
  logic             busy_q, busy_d;
  logic             start_eff, stop_eff;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      spd_q        <= '0;
      start_pend_q <= 1'b0;
      stop_pend_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      spd_q        <= spd_d;
      start_pend_q <= start_pend_d;
      stop_pend_q  <= stop_pend_d;
      busy_q       <= busy_d;
    end
  end

  // Requests arriving on the frame_start cycle itself are consumed with the pending ones.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    spd_d        = spd_q;
    target       = state_q;
    start_eff    = start_pend_q | gfx_io.start;
    stop_eff     = stop_pend_q  | gfx_io.stop;
    start_pend_d = start_eff;
    stop_pend_d  = stop_eff;
    hold_m1      = CNT_W'(hold_len(HOLD_FRAMES, spd_q) - 32'd1);

    if (frame_start) begin
      start_pend_d = 1'b0;
      stop_pend_d  = 1'b0;
      spd_d        = gfx_io.speed;
      case (state_q)
        IDLE: begin
          if (start_eff && !stop_eff) begin
            state_d = SPIN;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
        SPIN, STOPPING: begin
          // Stop beats start; start alone from STOPPING resumes the spin in place.
          if (stop_eff) begin
            target = STOPPING;
          end else if (start_eff) begin
            target = SPIN;
          end
          state_d = target;
          if (gfx_io.speed != spd_q) begin
            cnt_d = '0;
          end else if (cnt_q == hold_m1) begin
            cnt_d = '0;
            if ((target == STOPPING) && (idx_q == IDX_W'(NUM_FRAMES - 1))) begin
              idx_d   = '0;
              state_d = IDLE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign gfx_io.hpos        = hpos;
  assign gfx_io.vpos        = vpos;
  assign gfx_io.hsync       = hsync;
  assign gfx_io.vsync       = vsync;
  assign gfx_io.display_on  = display_on;
  assign gfx_io.frame_start = frame_start;
  assign gfx_io.anim_idx    = idx_q;
  assign gfx_io.anim_state  = state_q;
  assign gfx_io.busy        = busy_q;

endmodule
